// File: rtl/lab4_truth_table_sweeper_if.sv
// Bundle between the truth-table sweeper and the function under test.
// Carries stimulus, sampled response, results and the trace read port.
//
// Signals:
//   start         sweep request (slave -> master)
//   func_in       function block output (slave -> master)
//   tt_addr       truth-table read address (slave -> master)
//   vec_out       stimulus vector, MSB=a .. LSB=g (master -> slave)
//   busy, done    sweep status (master -> slave)
//   minterm_count number of vectors where func_in was 1
//   signature     CRC-16 over sampled func_in bits
//   tt_bit        captured func_in for tt_addr
interface lab4_truth_table_sweeper_if #(
  parameter int N_INPUTS = 7
);
  logic                start;
  logic                func_in;
  logic [N_INPUTS-1:0] tt_addr;
  logic [N_INPUTS-1:0] vec_out;
  logic                busy;
  logic                done;
  logic [N_INPUTS:0]   minterm_count;
  logic [15:0]         signature;
  logic                tt_bit;

  modport master (
    input  start,
    input  func_in,
    input  tt_addr,
    output vec_out,
    output busy,
    output done,
    output minterm_count,
    output signature,
    output tt_bit
  );

  modport slave (
    output start,
    output func_in,
    output tt_addr,
    input  vec_out,
    input  busy,
    input  done,
    input  minterm_count,
    input  signature,
    input  tt_bit
  );
endinterface

// File: rtl/lab4_truth_table_sweeper.sv
// Walks all 2^N_INPUTS input vectors, samples the function output,
// and accumulates a minterm count plus a CRC-16-CCITT signature.
//
// Ports:
//   clk  rising-edge clock
//   rst  synchronous active-high reset
//   bus  lab4_truth_table_sweeper_if.master (start, func_in, tt_addr in;
//        vec_out, busy, done, minterm_count, signature, tt_bit out)
// Parameters:
//   N_INPUTS      function input count (sweep length 2^N_INPUTS)
//   SETTLE_CYCLES extra hold cycles per vector before sampling, 0..15
// Build option:
//   LAB4_SWEEP_TRACE_EN  adds a truth-table capture readable via tt_addr
module lab4_truth_table_sweeper #(
  parameter int N_INPUTS      = 7,
  parameter int SETTLE_CYCLES = 1
) (
  input logic                        clk,
  input logic                        rst,
  lab4_truth_table_sweeper_if.master bus
);

  localparam int          NV       = 1 << N_INPUTS;
  localparam bit          NO_HOLD  = (SETTLE_CYCLES == 0);
  localparam logic [3:0]  SET_LAST =
    NO_HOLD ? 4'd0 : 4'(SETTLE_CYCLES - 1);
  localparam logic [15:0] CRC_POLY = 16'h1021;
  localparam logic [15:0] CRC_INIT = 16'hFFFF;

  localparam logic [N_INPUTS-1:0] VEC_ONE =
    {{(N_INPUTS-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE,
    HOLD,
    SAMPLE,
    FINISH
  } state_e;

  state_e              state_q, state_d;
  logic [N_INPUTS-1:0] vec_q, vec_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [N_INPUTS:0]   mint_q, mint_d;
  logic [15:0]         crc_q, crc_d;

  logic accept;
  logic sample;
  logic last_vec;
  logic fb;

  assign accept   = (state_q == IDLE) && bus.start;
  assign sample   = (state_q == SAMPLE);
  assign last_vec = &vec_q;
  assign fb       = crc_q[15] ^ bus.func_in;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      vec_q   <= '0;
      cnt_q   <= '0;
      mint_q  <= '0;
      crc_q   <= CRC_INIT;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      cnt_q   <= cnt_d;
      mint_q  <= mint_d;
      crc_q   <= crc_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start)
          state_d = NO_HOLD ? SAMPLE : HOLD;
      end
      HOLD: begin
        if (cnt_q == SET_LAST)
          state_d = SAMPLE;
      end
      SAMPLE: begin
        if (last_vec)
          state_d = FINISH;
        else if (!NO_HOLD)
          state_d = HOLD;
      end
      FINISH: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    vec_d  = vec_q;
    cnt_d  = cnt_q;
    mint_d = mint_q;
    crc_d  = crc_q;
    if (accept) begin
      vec_d  = '0;
      cnt_d  = '0;
      mint_d = '0;
      crc_d  = CRC_INIT;
    end else if (state_q == HOLD) begin
      cnt_d = cnt_q + 4'd1;
    end else if (sample) begin
      mint_d = mint_q + {{N_INPUTS{1'b0}}, bus.func_in};
      crc_d  = {crc_q[14:0], 1'b0} ^ (fb ? CRC_POLY : 16'h0000);
      // The all-ones vector ends the sweep, so vec never wraps.
      if (!last_vec) begin
        vec_d = vec_q + VEC_ONE;
        cnt_d = '0;
      end
    end
  end

  assign bus.vec_out       = vec_q;
  assign bus.busy          = (state_q == HOLD) || sample;
  assign bus.done          = (state_q == FINISH);
  assign bus.minterm_count = mint_q;
  assign bus.signature     = crc_q;

`ifdef LAB4_SWEEP_TRACE_EN
  logic [NV-1:0] tt_q;
  logic          tt_bit_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      tt_q     <= '0;
      tt_bit_q <= 1'b0;
    end else begin
      if (accept)
        tt_q <= '0;
      else if (sample)
        tt_q[vec_q] <= bus.func_in;
      tt_bit_q <= tt_q[bus.tt_addr];
    end
  end

  assign bus.tt_bit = tt_bit_q;
`else
  logic unused_tt_addr;
  assign unused_tt_addr = ^bus.tt_addr;
  assign bus.tt_bit     = 1'b0;
`endif

endmodule

// File: tb/tb_lab4_truth_table_sweeper.sv
// Self-checking bench for lab4_truth_table_sweeper.
// Drives table-defined functions into SETTLE=1 and SETTLE=0 instances.
module tb_lab4_truth_table_sweeper;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start_r = 1'b0;
  logic         sel = 1'b1;
  logic [6:0]   tt_addr_r = '0;
  logic [127:0] tt_ref = '0;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  lab4_truth_table_sweeper_if #(.N_INPUTS(7)) if1 ();
  lab4_truth_table_sweeper_if #(.N_INPUTS(7)) if0 ();

  lab4_truth_table_sweeper #(
    .N_INPUTS(7),
    .SETTLE_CYCLES(1)
  ) dut1 (
    .clk(clk),
    .rst(rst),
    .bus(if1)
  );

  lab4_truth_table_sweeper #(
    .N_INPUTS(7),
    .SETTLE_CYCLES(0)
  ) dut0 (
    .clk(clk),
    .rst(rst),
    .bus(if0)
  );

  assign if1.start   = start_r & sel;
  assign if0.start   = start_r & ~sel;
  assign if1.func_in = tt_ref[if1.vec_out];
  assign if0.func_in = tt_ref[if0.vec_out];
  assign if1.tt_addr = tt_addr_r;
  assign if0.tt_addr = tt_addr_r;

  logic        o_busy, o_done, o_tt;
  logic [6:0]  o_vec;
  logic [7:0]  o_cnt;
  logic [15:0] o_sig;

  always_comb begin
    o_busy = sel ? if1.busy          : if0.busy;
    o_done = sel ? if1.done          : if0.done;
    o_tt   = sel ? if1.tt_bit        : if0.tt_bit;
    o_vec  = sel ? if1.vec_out       : if0.vec_out;
    o_cnt  = sel ? if1.minterm_count : if0.minterm_count;
    o_sig  = sel ? if1.signature     : if0.signature;
  end

  task automatic check_eq(input string tag,
                          input logic [31:0] got,
                          input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic int ref_count(input logic [127:0] t);
    int c = 0;
    for (int i = 0; i < 128; i++) c += int'(t[i]);
    return c;
  endfunction

  function automatic logic [15:0] ref_crc(input logic [127:0] t);
    logic [15:0] c = 16'hFFFF;
    logic        f;
    for (int i = 0; i < 128; i++) begin
      f = c[15] ^ t[i];
      c = {c[14:0], 1'b0};
      if (f) c = c ^ 16'h1021;
    end
    return c;
  endfunction

  task automatic check_reset(input string tag);
    check_eq({tag, ".vec"},  32'(o_vec),  32'd0);
    check_eq({tag, ".busy"}, 32'(o_busy), 32'd0);
    check_eq({tag, ".done"}, 32'(o_done), 32'd0);
    check_eq({tag, ".cnt"},  32'(o_cnt),  32'd0);
    check_eq({tag, ".sig"},  32'(o_sig),  32'hFFFF);
    check_eq({tag, ".tt"},   32'(o_tt),   32'd0);
  endtask

  task automatic run_sweep(input int settle,
                           input bit pulses,
                           input string tag);
    int total;
    int busy_n;
    int done_n;
    int done_at;
    total   = 128 * (settle + 1);
    busy_n  = 0;
    done_n  = 0;
    done_at = -1;
    @(negedge clk);
    start_r = 1'b1;
    @(posedge clk);
    for (int cyc = 1; cyc <= total + 4; cyc++) begin
      @(negedge clk);
      start_r = 1'b0;
      if (pulses && o_busy && (o_vec == 7'd10 || o_vec == 7'd90))
        start_r = 1'b1;
      if (o_busy) busy_n++;
      if (o_done) begin
        done_n++;
        if (done_at < 0) begin
          done_at = cyc;
          check_eq({tag, ".cnt@done"}, 32'(o_cnt),
                   32'(ref_count(tt_ref)));
        end
      end
    end
    start_r = 1'b0;
    check_eq({tag, ".busy_cycles"}, 32'(busy_n), 32'(total));
    check_eq({tag, ".done_at"}, 32'(done_at), 32'(total + 1));
    check_eq({tag, ".done_pulses"}, 32'(done_n), 32'd1);
    check_eq({tag, ".busy_idle"}, 32'(o_busy), 32'd0);
    check_eq({tag, ".cnt"}, 32'(o_cnt), 32'(ref_count(tt_ref)));
    check_eq({tag, ".sig"}, 32'(o_sig), 32'(ref_crc(tt_ref)));
  endtask

  task automatic read_tt(input logic [6:0] a, input string tag);
    @(negedge clk);
    tt_addr_r = a;
    @(negedge clk);
`ifdef LAB4_SWEEP_TRACE_EN
    check_eq(tag, 32'(o_tt), 32'(tt_ref[a]));
`else
    check_eq(tag, 32'(o_tt), 32'd0);
`endif
  endtask

  initial begin
    int got_at;
    bit hit;
    logic [6:0] ra;

    repeat (3) @(negedge clk);
    sel = 1'b1;
    check_reset("rst1");
    sel = 1'b0;
    check_reset("rst0");
    rst = 1'b0;
    sel = 1'b1;

    tt_ref = '0;
    run_sweep(1, 1'b0, "zeros");

    tt_ref = '1;
    run_sweep(1, 1'b0, "ones");

    sel = 1'b0;
    for (int i = 0; i < 128; i++) tt_ref[i] = (i % 2 == 1);
    run_sweep(0, 1'b0, "g_s0");
    sel = 1'b1;

    tt_ref = '0;
    tt_ref[127] = 1'b1;
    run_sweep(1, 1'b0, "and");
    read_tt(7'd127, "and.tt127");
    read_tt(7'd126, "and.tt126");

    for (int k = 0; k < 3; k++) begin
      tt_ref = {$urandom, $urandom, $urandom, $urandom};
      sel = k[0];
      run_sweep(k[0] ? 1 : 0, 1'b0, $sformatf("rand%0d", k));
      ra = 7'($urandom_range(0, 127));
      read_tt(ra, $sformatf("rand%0d.tt", k));
    end
    sel = 1'b1;

    tt_ref = {$urandom, $urandom, $urandom, $urandom};
    @(negedge clk);
    start_r = 1'b1;
    @(negedge clk);
    start_r = 1'b0;
    hit = 1'b0;
    for (int c = 0; c < 400 && !hit; c++) begin
      @(negedge clk);
      if (o_busy && o_vec == 7'd40) hit = 1'b1;
    end
    check_eq("midrst.reach40", 32'(hit), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check_reset("midrst");
    rst = 1'b0;
    run_sweep(1, 1'b0, "after_rst");

    tt_ref = {$urandom, $urandom, $urandom, $urandom};
    run_sweep(1, 1'b1, "pulses");

    tt_ref = '0;
    @(negedge clk);
    start_r = 1'b1;
    @(posedge clk);
    got_at = -1;
    for (int c = 1; c <= 300 && got_at < 0; c++) begin
      @(negedge clk);
      if (o_done) got_at = c;
    end
    check_eq("held.done_at", 32'(got_at), 32'd257);
    @(negedge clk);
    check_eq("held.idle_busy", 32'(o_busy), 32'd0);
    @(negedge clk);
    check_eq("held.restart_busy", 32'(o_busy), 32'd1);
    check_eq("held.restart_vec", 32'(o_vec), 32'd0);
    start_r = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_reset("held.rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
